sd_card_cmd_responder: RTL and testbench
========================================

# sd_card_cmd_responder

Card-side endpoint of the SD CMD line: deserializes 48-bit command tokens driven by the host's `command_to_card`, checks framing and CRC7, and hands index/argument to a card core. After a core-supplied response is accepted and the Ncr gap elapses, it serializes a 48-bit response token (R1/R3/R6/R7 format) back to the host. It is the bench-side and card-model counterpart of the host CMD path. It runs on the card clock, one bit per cycle.

## Interface
- `NCR`, default 2: idle cycles between response acceptance and the response start bit; legal range 2..64.
- `CLK` input 1: card clock; every rising edge samples or drives one CMD bit.
- `RESET` input 1: synchronous, active-low reset.
- `cmd_in` input 1: CMD line from the host; idle is 1.
- `cmd_out` output 1: serialized response bit; reset value 1.
- `cmd_oe` output 1: response drive enable; reset value 0.
- `cmd_valid` output 1: one-cycle pulse when a good command has been decoded; reset value 0.
- `cmd_index` output 6: decoded command index; held until the next good command; reset value 0.
- `cmd_arg` output 32: decoded argument; held like `cmd_index`; reset value 0.
- `crc_err` output 1: one-cycle pulse when the CRC7 does not match; reset value 0.
- `frm_err` output 1: one-cycle pulse on transmission bit ≠ 1 or end bit ≠ 1; reset value 0.
- `resp_valid` input 1: core offers a response (only in WAIT_RESP).
- `resp_skip` input 1: core declares no response, e.g. CMD0.
- `resp_index` input 6 and `resp_arg` input 32: response fields, sampled when `resp_valid` is accepted.
- `resp_ready` output 1: high in WAIT_RESP only; reset value 0.
- `busy` output 1: high in every state except IDLE; reset value 0.

## Operation
- **States:** IDLE, RX, CHECK, WAIT_RESP, GAP, TX.
- **IDLE**
  - `cmd_in`=0 is the start bit. Go to RX with bit counter = 1 and the CRC seeded with bit 0.
- **RX**
  - Shift `cmd_in` into a 48-bit shift register.
  - CRC7 (x^7+x^3+1, initial value 0) runs over bits 0..39.
  - After bit 47 (the end bit) is sampled, go to CHECK.
- **CHECK** (one cycle)
  - If the transmission bit (bit 1) ≠ 1 or the end bit ≠ 1: pulse `frm_err`, go to IDLE.
  - Else if the received CRC ≠ the computed CRC: pulse `crc_err`, go to IDLE.
  - Else: pulse `cmd_valid`, update `cmd_index`/`cmd_arg`, go to WAIT_RESP.
  - `frm_err` has priority over `crc_err`; only one flag pulses.
- **WAIT_RESP**
  - `resp_ready`=1. No timeout.
  - `resp_skip` returns to IDLE.
  - `resp_valid` latches the fields, loads the gap counter with NCR, and goes to GAP.
  - If both are high in the same cycle, `resp_skip` wins.
  - `cmd_in` is ignored in this state.
- **GAP**
  - Count down NCR cycles with `cmd_oe`=0, then go to TX.
- **TX** (48 cycles, `cmd_oe`=1)
  - Bit order: start bit 0, transmission bit 0, index[5:0] MSB first, arg[31:0] MSB first, CRC7 computed over the preceding 40 bits, end bit 1.
  - After the end bit, go to IDLE.
- **Outside TX:** `cmd_oe`=0 and `cmd_out`=1.
- **Reset mid-operation:** any state returns to IDLE and all outputs take their reset values; a partial token is discarded with no error pulse.
- **Commands arriving during GAP/TX:** not detected. The host must respect Ncc.

## Timing
- `cmd_valid`, `crc_err` and `frm_err` assert in the cycle after the end bit is sampled, i.e. 49 cycles after the start bit was sampled.
- Response start bit appears on `cmd_out` exactly NCR+1 cycles after the `resp_valid` acceptance edge.
  - `cmd_oe` rises in the same cycle as the start bit.
  - `cmd_oe` falls in the cycle after the end bit.
- Back-to-back: IDLE can detect a new start bit in the first cycle after returning to IDLE.

## Structure
- Add to `defines.v`:
  - token length 48
  - CRC7 polynomial 7'h09
  - state encodings
  - NCR minimum 2
- Sub-module `sd_crc7`: serial CRC7 with clear, enable and bit input, exposing crc[6:0].
  - Instantiated twice: one for RX, one for TX.
  - Reusable by the host CMD transmitter.

## Test plan
- CMD0: token 48'h400000000095 → `cmd_valid` at cycle 49, index 0, arg 0. Then `resp_skip` → IDLE with `cmd_oe` never high.
- CMD8: token 48'h48000001AA87 → index 8, arg 32'h000001AA. Then `resp_valid` with index 8, arg 32'h000001AA, NCR=2 → `cmd_out` emits 48'h08000001AA13, start bit 3 cycles after acceptance.
- CMD8 token with the CRC field changed to 7'h42 → `crc_err` single pulse, no `cmd_valid`, `busy` back to 0 the next cycle.
- CMD0 token with the end bit forced to 0 and a bad CRC → only `frm_err` pulses.
- RESET low at RX bit 20, and again at TX bit 10 → next cycle `cmd_oe`=0, `busy`=0, no flag pulses. A subsequent CMD0 then decodes correctly.
- Two CMD0 tokens separated by one idle cycle (`resp_skip` asserted immediately) → two `cmd_valid` pulses.

Source files
------------

// File: rtl/sd_card_cmd_responder_pkg.sv
// Shared constants, state encoding and CRC7 step for the SD card-side CMD responder.
package sd_card_cmd_responder_pkg;

  localparam int unsigned TOKEN_LEN = 48;
  localparam int unsigned CRC_SPAN  = 40;
  localparam int unsigned NCR_MIN   = 2;
  localparam int unsigned NCR_MAX   = 64;
  localparam logic [6:0]  CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_CHECK,
    ST_WAIT_RESP,
    ST_GAP,
    ST_TX
  } state_e;

  typedef struct packed {
    logic [5:0]  index;
    logic [31:0] arg;
  } cmd_fields_t;

  // One serial step of CRC7 (x^7 + x^3 + 1), MSB-first.
  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator; clear together with enable seeds it with the first bit.
module sd_crc7
  import sd_card_cmd_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (clr) begin
      crc <= en ? crc7_next(7'h00, bit_in) : 7'h00;
    end else if (en) begin
      crc <= crc7_next(crc, bit_in);
    end
  end

endmodule

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD endpoint: receives 48-bit commands, checks framing/CRC7,
// and serializes a core-supplied 48-bit response after the Ncr gap.
module sd_card_cmd_responder
  import sd_card_cmd_responder_pkg::*;
#(
  parameter int unsigned NCR = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cmd_in,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        crc_err,
  output logic        frm_err,
  input  logic        resp_valid,
  input  logic        resp_skip,
  input  logic [5:0]  resp_index,
  input  logic [31:0] resp_arg,
  output logic        resp_ready,
  output logic        busy
);

  localparam int unsigned NCR_EFF = (NCR < NCR_MIN) ? NCR_MIN :
                                    ((NCR > NCR_MAX) ? NCR_MAX : NCR);
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned GAP_W   = 7;
  localparam int unsigned SR_W    = TOKEN_LEN - 2;
  localparam int unsigned TXD_W   = CRC_SPAN;

  localparam logic [CNT_W-1:0] RX_LAST     = CNT_W'(TOKEN_LEN - 1);
  localparam logic [CNT_W-1:0] CRC_LAST    = CNT_W'(CRC_SPAN - 1);
  localparam logic [CNT_W-1:0] TX_CRC_FST  = CNT_W'(CRC_SPAN);
  localparam logic [CNT_W-1:0] TX_CRC_LST  = CNT_W'(TOKEN_LEN - 2);
  localparam logic [CNT_W-1:0] TX_END      = CNT_W'(TOKEN_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD    = GAP_W'(NCR_EFF);

  state_e            state, state_d;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_d;
  logic [SR_W-1:0]   rx_sr, rx_sr_d;
  logic [TXD_W-1:0]  tx_data, tx_data_d;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_d;
  logic              cmd_out_d, cmd_oe_d, cmd_valid_d, crc_err_d, frm_err_d;
  logic              resp_ready_d, busy_d;
  logic [5:0]        cmd_index_d;
  logic [31:0]       cmd_arg_d;

  logic              rx_crc_clr, rx_crc_en;
  logic              tx_crc_clr, tx_crc_en;
  logic [6:0]        rx_crc, tx_crc;
  logic [2:0]        crc_idx;
  cmd_fields_t       resp_f;

  assign resp_f  = '{index: resp_index, arg: resp_arg};
  assign crc_idx = 3'(TX_CRC_LST - bit_cnt);

  sd_crc7 u_rx_crc (
    .clk    (CLK),
    .rst_n  (RESET),
    .clr    (rx_crc_clr),
    .en     (rx_crc_en),
    .bit_in (cmd_in),
    .crc    (rx_crc)
  );

  sd_crc7 u_tx_crc (
    .clk    (CLK),
    .rst_n  (RESET),
    .clr    (tx_crc_clr),
    .en     (tx_crc_en),
    .bit_in (tx_data[TXD_W-1]),
    .crc    (tx_crc)
  );

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_data    <= '0;
      gap_cnt    <= '0;
      cmd_out    <= 1'b1;
      cmd_oe     <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_index  <= '0;
      cmd_arg    <= '0;
      crc_err    <= 1'b0;
      frm_err    <= 1'b0;
      resp_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      bit_cnt    <= bit_cnt_d;
      rx_sr      <= rx_sr_d;
      tx_data    <= tx_data_d;
      gap_cnt    <= gap_cnt_d;
      cmd_out    <= cmd_out_d;
      cmd_oe     <= cmd_oe_d;
      cmd_valid  <= cmd_valid_d;
      cmd_index  <= cmd_index_d;
      cmd_arg    <= cmd_arg_d;
      crc_err    <= crc_err_d;
      frm_err    <= frm_err_d;
      resp_ready <= resp_ready_d;
      busy       <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    rx_sr_d     = rx_sr;
    tx_data_d   = tx_data;
    gap_cnt_d   = gap_cnt;
    cmd_out_d   = 1'b1;
    cmd_oe_d    = 1'b0;
    cmd_valid_d = 1'b0;
    crc_err_d   = 1'b0;
    frm_err_d   = 1'b0;
    cmd_index_d = cmd_index;
    cmd_arg_d   = cmd_arg;
    rx_crc_clr  = 1'b0;
    rx_crc_en   = 1'b0;
    tx_crc_clr  = 1'b0;
    tx_crc_en   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!cmd_in) begin
          state_d    = ST_RX;
          bit_cnt_d  = CNT_W'(1);
          rx_crc_clr = 1'b1;
          rx_crc_en  = 1'b1;
        end
      end

      ST_RX: begin
        rx_sr_d   = {rx_sr[SR_W-2:0], cmd_in};
        rx_crc_en = (bit_cnt <= CRC_LAST);
        // Verdict is taken as the end bit arrives so flags show in the CHECK cycle.
        if (bit_cnt == RX_LAST) begin
          state_d = ST_CHECK;
          if (!(rx_sr[SR_W-1] && cmd_in)) begin
            frm_err_d = 1'b1;
          end else if (rx_sr[6:0] != rx_crc) begin
            crc_err_d = 1'b1;
          end else begin
            cmd_valid_d = 1'b1;
            cmd_index_d = rx_sr[44:39];
            cmd_arg_d   = rx_sr[38:7];
          end
        end else begin
          bit_cnt_d = bit_cnt + CNT_W'(1);
        end
      end

      ST_CHECK: begin
        state_d = cmd_valid ? ST_WAIT_RESP : ST_IDLE;
      end

      ST_WAIT_RESP: begin
        if (resp_skip) begin
          state_d = ST_IDLE;
        end else if (resp_valid) begin
          state_d   = ST_GAP;
          tx_data_d = {2'b00, resp_f};
          gap_cnt_d = GAP_LOAD;
        end
      end

      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_d    = ST_TX;
          cmd_oe_d   = 1'b1;
          cmd_out_d  = tx_data[TXD_W-1];
          tx_data_d  = {tx_data[TXD_W-2:0], 1'b0};
          tx_crc_clr = 1'b1;
          tx_crc_en  = 1'b1;
          bit_cnt_d  = CNT_W'(1);
        end else begin
          gap_cnt_d = gap_cnt - GAP_W'(1);
        end
      end

      ST_TX: begin
        bit_cnt_d = bit_cnt + CNT_W'(1);
        cmd_oe_d  = 1'b1;
        if (bit_cnt < TX_CRC_FST) begin
          cmd_out_d = tx_data[TXD_W-1];
          tx_data_d = {tx_data[TXD_W-2:0], 1'b0};
          tx_crc_en = 1'b1;
        end else if (bit_cnt < TX_END) begin
          cmd_out_d = tx_crc[crc_idx];
        end else if (bit_cnt == TX_END) begin
          cmd_out_d = 1'b1;
        end else begin
          state_d   = ST_IDLE;
          cmd_oe_d  = 1'b0;
          bit_cnt_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    resp_ready_d = (state_d == ST_WAIT_RESP);
    busy_d       = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Directed bench for sd_card_cmd_responder: decode, error flags, response
// serialization timing, mid-operation reset and back-to-back commands.
module tb_sd_card_cmd_responder;

  localparam int unsigned NCR = 2;
  localparam logic [47:0] CMD0_TOK   = 48'h400000000095;
  localparam logic [47:0] CMD8_TOK   = 48'h48000001AA87;
  localparam logic [47:0] CMD8_BADC  = 48'h48000001AA85;
  localparam logic [47:0] CMD0_BADF  = 48'h400000000000;
  localparam logic [47:0] R7_EXPECT  = 48'h08000001AA13;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        cmd_in;
  logic        cmd_out, cmd_oe, cmd_valid, crc_err, frm_err;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        resp_valid, resp_skip;
  logic [5:0]  resp_index;
  logic [31:0] resp_arg;
  logic        resp_ready, busy;

  int n_cmp = 0;
  int n_mis = 0;
  int n_valid = 0, n_crc = 0, n_frm = 0, n_oe = 0;

  always #5 CLK = ~CLK;

  sd_card_cmd_responder #(.NCR(NCR)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .cmd_in     (cmd_in),
    .cmd_out    (cmd_out),
    .cmd_oe     (cmd_oe),
    .cmd_valid  (cmd_valid),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg),
    .crc_err    (crc_err),
    .frm_err    (frm_err),
    .resp_valid (resp_valid),
    .resp_skip  (resp_skip),
    .resp_index (resp_index),
    .resp_arg   (resp_arg),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge CLK) begin
    if (cmd_valid) n_valid++;
    if (crc_err)   n_crc++;
    if (frm_err)   n_frm++;
    if (cmd_oe)    n_oe++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drives a token MSB first, one bit per edge; returns in the cycle after the end bit.
  task automatic send_token(input logic [47:0] t, input string tag);
    for (int i = 47; i >= 0; i--) begin
      cmd_in = t[i];
      if (i == 0)
        chk({tag, "_no_early_flag"}, 64'({cmd_valid, crc_err, frm_err}), 64'd0);
      tick(1);
    end
    cmd_in = 1'b1;
  endtask

  initial begin
    logic [47:0] tok;
    logic [47:0] resp_bits;
    int          oe_drop;
    int          snap_v, snap_c, snap_f;

    RESET      = 1'b0;
    cmd_in     = 1'b1;
    resp_valid = 1'b0;
    resp_skip  = 1'b0;
    resp_index = '0;
    resp_arg   = '0;
    resp_bits  = '0;
    oe_drop    = 0;
    tick(3);

    chk("rst_cmd_out",   64'(cmd_out), 64'd1);
    chk("rst_cmd_oe",    64'(cmd_oe), 64'd0);
    chk("rst_flags",     64'({cmd_valid, crc_err, frm_err}), 64'd0);
    chk("rst_index_arg", 64'({cmd_index, cmd_arg}), 64'd0);
    chk("rst_ready_busy", 64'({resp_ready, busy}), 64'd0);
    RESET = 1'b1;
    tick(2);

    // CMD0 decode, then skip the response
    send_token(CMD0_TOK, "cmd0");
    chk("cmd0_valid", 64'(cmd_valid), 64'd1);
    chk("cmd0_index", 64'(cmd_index), 64'd0);
    chk("cmd0_arg",   64'(cmd_arg), 64'd0);
    chk("cmd0_errs",  64'({crc_err, frm_err}), 64'd0);
    chk("cmd0_busy",  64'(busy), 64'd1);
    tick(1);
    chk("cmd0_valid_pulse", 64'(cmd_valid), 64'd0);
    chk("cmd0_ready", 64'(resp_ready), 64'd1);
    resp_skip = 1'b1;
    tick(1);
    resp_skip = 1'b0;
    chk("cmd0_skip_idle", 64'({resp_ready, busy}), 64'd0);
    chk("cmd0_no_oe", 64'(n_oe), 64'd0);

    // CMD8 decode and R7 response
    send_token(CMD8_TOK, "cmd8");
    chk("cmd8_valid", 64'(cmd_valid), 64'd1);
    chk("cmd8_index", 64'(cmd_index), 64'd8);
    chk("cmd8_arg",   64'(cmd_arg), 64'h1AA);
    tick(1);
    chk("cmd8_ready", 64'(resp_ready), 64'd1);
    resp_valid = 1'b1;
    resp_index = 6'd8;
    resp_arg   = 32'h0000_01AA;
    tick(1);
    resp_valid = 1'b0;
    chk("gap_a0_oe", 64'({cmd_oe, busy, resp_ready}), 64'b010);
    tick(1);
    chk("gap_a1_oe", 64'({cmd_oe, cmd_out}), 64'b01);
    tick(1);
    chk("gap_a2_oe", 64'({cmd_oe, cmd_out}), 64'b01);
    tick(1);
    chk("start_a3", 64'({cmd_oe, cmd_out}), 64'b10);
    for (int k = 0; k < 48; k++) begin
      resp_bits[47-k] = cmd_out;
      if (!cmd_oe) oe_drop++;
      tick(1);
    end
    chk("r7_token",   64'(resp_bits), 64'(R7_EXPECT));
    chk("r7_oe_held", 64'(oe_drop), 64'd0);
    chk("r7_after",   64'({cmd_oe, cmd_out, busy}), 64'b010);

    // CRC error
    snap_v = n_valid;
    snap_c = n_crc;
    send_token(CMD8_BADC, "crcbad");
    chk("crc_flags", 64'({cmd_valid, crc_err, frm_err}), 64'b010);
    chk("crc_index_held", 64'(cmd_index), 64'd8);
    tick(1);
    chk("crc_busy_drop", 64'({busy, crc_err}), 64'd0);
    chk("crc_pulse_cnt", 64'({16'(n_valid - snap_v), 16'(n_crc - snap_c)}), 64'h0000_0001);

    // Framing error with bad CRC: only frm_err
    snap_c = n_crc;
    snap_f = n_frm;
    send_token(CMD0_BADF, "frmbad");
    chk("frm_flags", 64'({cmd_valid, crc_err, frm_err}), 64'b001);
    tick(1);
    chk("frm_busy_drop", 64'(busy), 64'd0);
    chk("frm_pulse_cnt", 64'({16'(n_crc - snap_c), 16'(n_frm - snap_f)}), 64'h0000_0001);

    // Reset at RX bit 20
    snap_v = n_valid;
    snap_c = n_crc;
    snap_f = n_frm;
    tok = CMD0_TOK;
    for (int i = 47; i > 27; i--) begin
      cmd_in = tok[i];
      tick(1);
    end
    chk("rx_mid_busy", 64'(busy), 64'd1);
    cmd_in = tok[27];
    RESET  = 1'b0;
    tick(1);
    chk("rx_rst_state", 64'({cmd_oe, busy}), 64'd0);
    RESET  = 1'b1;
    cmd_in = 1'b1;
    tick(1);
    chk("rx_rst_noflag", 64'({16'(n_valid - snap_v), 16'(n_crc - snap_c), 16'(n_frm - snap_f)}), 64'd0);

    // Reset at TX bit 10
    send_token(CMD0_TOK, "cmd0_tx");
    tick(1);
    resp_valid = 1'b1;
    resp_index = 6'd3;
    resp_arg   = 32'hDEAD_BEEF;
    tick(1);
    resp_valid = 1'b0;
    tick(NCR + 1 + 10);
    chk("tx_mid_oe", 64'(cmd_oe), 64'd1);
    snap_v = n_valid;
    snap_c = n_crc;
    snap_f = n_frm;
    RESET = 1'b0;
    tick(1);
    chk("tx_rst_state", 64'({cmd_oe, cmd_out, busy, resp_ready}), 64'b0100);
    RESET = 1'b1;
    tick(1);
    chk("tx_rst_noflag", 64'({16'(n_valid - snap_v), 16'(n_crc - snap_c), 16'(n_frm - snap_f)}), 64'd0);
    send_token(CMD0_TOK, "cmd0_post_rst");
    chk("post_rst_valid", 64'({cmd_valid, cmd_index}), 64'h40);
    tick(1);
    resp_skip = 1'b1;
    tick(1);
    resp_skip = 1'b0;

    // Back-to-back CMD0 with immediate skip
    snap_v = n_valid;
    resp_skip = 1'b1;
    send_token(CMD0_TOK, "b2b_1");
    chk("b2b_first", 64'(cmd_valid), 64'd1);
    tick(2);
    send_token(CMD0_TOK, "b2b_2");
    chk("b2b_second", 64'(cmd_valid), 64'd1);
    tick(2);
    resp_skip = 1'b0;
    chk("b2b_count", 64'(n_valid - snap_v), 64'd2);
    chk("b2b_idle", 64'({busy, cmd_oe}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
